// File: rtl/bsc_defs.sv
// bsc_defs: shared arbiter state encodings and width helper for button_scan_ctrl
package bsc_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    // ceil(log2(v)), never below 1 so single-value ranges still get a bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++)
            if ((1 << k) < v) r = k + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle sample-enable pulse
module tick_gen
    import bsc_defs::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic TICK
);

    localparam int PW = clog2(PRESCALE);

    logic [PW-1:0] pcnt;

    // count 0..PRESCALE-1 and wrap
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) pcnt <= '0;
        else          pcnt <= (pcnt == PW'(PRESCALE - 1)) ? '0 : pcnt + 1'b1;

    assign TICK = (pcnt == PW'(PRESCALE - 1));

endmodule

// File: rtl/button_scan_ctrl.sv
// button_scan_ctrl: debounce a bank of buttons and arbitrate press events round-robin
module button_scan_ctrl
    import bsc_defs::*;
#(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = 3,
    localparam int IW      = clog2(CHANNELS)
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [CHANNELS-1:0] IN_SIGNALS,
    output logic                TICK,
    output logic [CHANNELS-1:0] LEVELS,
    output logic                EVT_VALID,
    input  logic                EVT_READY,
    output logic [IW-1:0]       EVT_ID,
    output logic [CHANNELS-1:0] OVERRUN
);

    logic [CHANNELS-1:0] sync1, sync2, rise, pend, acc_vec;
    logic [IW-1:0]       rr, rr_d, id_d;
    logic                accept;
    arb_state_t          state, state_d;

    // first pending index searching r, r+1, ... modulo CHANNELS
    function automatic logic [IW-1:0] rr_pick(input logic [CHANNELS-1:0] p, input logic [IW-1:0] r);
        logic [IW-1:0] sel;
        sel = r;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (p[(int'(r) + k) % CHANNELS]) sel = IW'((int'(r) + k) % CHANNELS);
        return sel;
    endfunction

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TICK    (TICK)
    );

    // two-flop synchroniser for the raw pins
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= IN_SIGNALS;
            sync2 <= sync1;
        end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        // stability counter: restarts whenever input agrees with the level
        always_ff @(posedge CLK or negedge RESET_N)
            if (!RESET_N) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (TICK) begin
                cnt <= (&cnt) ? '0 : cnt + 1'b1;
                lvl <= (&cnt) ? sync2[i] : lvl;
            end
        assign LEVELS[i] = lvl;
        assign rise[i]   = TICK && sync2[i] && !lvl && (&cnt);
    end

    assign accept  = EVT_VALID && EVT_READY;
    assign acc_vec = {{(CHANNELS-1){1'b0}}, accept} << EVT_ID;

    // pending flags (a new press beats a same-cycle accept) and sticky overrun
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            pend    <= '0;
            OVERRUN <= '0;
        end else begin
            pend    <= rise | (pend & ~acc_vec);
            OVERRUN <= OVERRUN | (rise & pend & ~acc_vec);
        end

    // arbiter state, offered id and round-robin pointer
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            state  <= ST_IDLE;
            EVT_ID <= '0;
            rr     <= '0;
        end else begin
            state  <= state_d;
            EVT_ID <= id_d;
            rr     <= rr_d;
        end

    // pick the next event in IDLE, hold it in OFFER until accepted
    always_comb begin
        state_d = state;
        id_d    = EVT_ID;
        rr_d    = rr;
        if (state == ST_IDLE) begin
            if (|pend) begin
                state_d = ST_OFFER;
                id_d    = rr_pick(pend, rr);
            end
        end else if (EVT_READY) begin
            state_d = ST_IDLE;
            rr_d    = (EVT_ID == IW'(CHANNELS - 1)) ? '0 : EVT_ID + 1'b1;
        end
    end

    assign EVT_VALID = (state == ST_OFFER);

endmodule

// File: tb/tb_button_scan_ctrl.sv
// tb_button_scan_ctrl: scoreboard bench for debounce latency, arbitration and overrun
module tb_button_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_sig = '0;
    logic       tick;
    logic [3:0] levels;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_id;
    logic [3:0] overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int model_rr = 0;
    int exp_q[$];

    button_scan_ctrl #(.CHANNELS(4), .PRESCALE(4), .CNT_W(2)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .IN_SIGNALS (in_sig),
        .TICK       (tick),
        .LEVELS     (levels),
        .EVT_VALID  (evt_valid),
        .EVT_READY  (evt_ready),
        .EVT_ID     (evt_id),
        .OVERRUN    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] p, input int r);
        for (int k = 0; k < 4; k++)
            if (p[(r + k) % 4]) return (r + k) % 4;
        return -1;
    endfunction

    // event monitor: pops the scoreboard on each handshake, checks hold and gap rules
    logic       prev_v = 1'b0, prev_hs = 1'b0;
    logic [1:0] prev_id = '0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) check("gap", 32'(evt_valid), 0);
            if (prev_v && !prev_hs) begin
                check("hold_valid", 32'(evt_valid), 1);
                check("hold_id", 32'(evt_id), 32'(prev_id));
            end
            prev_hs = evt_valid && evt_ready;
            if (prev_hs) begin
                hs_cnt++;
                if (exp_q.size() == 0) check("unexpected_evt", 32'(evt_id) + 1, 0);
                else begin
                    int e;
                    e = exp_q.pop_front();
                    check("evt_id", 32'(evt_id), 32'(e));
                    model_rr = (e + 1) % 4;
                end
            end
            prev_v  = evt_valid;
            prev_id = evt_id;
        end
    end

    task automatic apply_reset();
        rst_n  = 1'b0;
        in_sig = '0;
        #1;
        check("rst_tick", 32'(tick), 0);
        check("rst_levels", 32'(levels), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_id", 32'(evt_id), 0);
        check("rst_overrun", 32'(overrun), 0);
        exp_q.delete();
        model_rr = 0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
    endtask

    task automatic align_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        check("tick_seen", 32'(tick), 1);
    endtask

    // wait for LEVELS[ch]==v, counting ticks seen before it changes
    task automatic wait_lvl(input int ch, input logic v, output int ticks);
        bit done;
        done  = 0;
        ticks = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (levels[ch] == v) done = 1;
            else if (tick) ticks++;
        end
        if (!done) begin
            check("lvl_timeout", 32'(levels[ch]), 32'(v));
            ticks = -1;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!evt_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 32'(evt_valid), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t, h0, f;
        apply_reset();

        // 1: ch2 held -> level on 4th tick, event id 2
        align_tick();
        in_sig[2] = 1'b1;
        exp_q.push_back(2);
        wait_lvl(2, 1'b1, t);
        check("t1_latency", 32'(t), 4);
        drain();
        check("t1_rr", 32'(model_rr), 3);

        // 2: 2-tick glitch on ch1 is filtered
        h0 = hs_cnt;
        in_sig[1] = 1'b1;
        repeat (8) @(negedge clk);
        in_sig[1] = 1'b0;
        repeat (30) @(negedge clk);
        check("t2_levels", 32'(levels), 32'h4);
        check("t2_no_evt", 32'(hs_cnt - h0), 0);

        // 5: release ch2 -> falls on 4th tick, no event
        h0 = hs_cnt;
        align_tick();
        in_sig[2] = 1'b0;
        wait_lvl(2, 1'b0, t);
        check("t5_latency", 32'(t), 4);
        repeat (5) @(negedge clk);
        check("t5_no_evt", 32'(hs_cnt - h0), 0);

        // 3: ch0 and ch3 together from a fresh pointer
        apply_reset();
        @(negedge clk);
        f = first_from(4'b1001, model_rr);
        exp_q.push_back(f);
        exp_q.push_back(f == 0 ? 3 : 0);
        in_sig = 4'b1001;
        wait_lvl(0, 1'b1, t);
        check("t3_levels", 32'(levels), 32'h9);
        drain();
        in_sig = '0;
        wait_lvl(3, 1'b0, t);

        // 4: consumer stalled, second press on ch1 overruns
        h0 = hs_cnt;
        evt_ready = 1'b0;
        in_sig[1] = 1'b1;
        exp_q.push_back(1);
        wait_lvl(1, 1'b1, t);
        wait_valid();
        check("t4_id", 32'(evt_id), 1);
        check("t4_no_ovr", 32'(overrun), 0);
        in_sig[1] = 1'b0;
        wait_lvl(1, 1'b0, t);
        in_sig[1] = 1'b1;
        wait_lvl(1, 1'b1, t);
        @(negedge clk);
        check("t4_overrun", 32'(overrun), 32'h2);
        check("t4_still_valid", 32'(evt_valid), 1);
        evt_ready = 1'b1;
        drain();
        repeat (10) @(negedge clk);
        check("t4_one_evt", 32'(hs_cnt - h0), 1);
        check("t4_sticky", 32'(overrun), 32'h2);

        // 6: reset during OFFER drops the event
        evt_ready = 1'b0;
        in_sig[1] = 1'b0;
        wait_lvl(1, 1'b0, t);
        in_sig[2] = 1'b1;
        exp_q.push_back(2);
        wait_lvl(2, 1'b1, t);
        wait_valid();
        h0 = hs_cnt;
        apply_reset();
        repeat (40) @(negedge clk);
        check("t6_no_stale", 32'(hs_cnt - h0), 0);
        check("t6_valid", 32'(evt_valid), 0);
        check("t6_levels", 32'(levels), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
